reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-read-port register file for the ARM datapath; successor to the
//  fixed 2-read/1-write file. Adds configurable port count, hardwired zero register
//  (XZR), same-cycle write-to-read bypass, and a sequential clear engine run after reset.
//  Sits between decode (read addresses) and writeback (write port).
// PARAMETERS
//  DATA_WIDTH  32  bits per register
//  ADDR_WIDTH  5   register address width
//  NUM_REGS    32  implemented registers (<= 2**ADDR_WIDTH)
//  NUM_READ    2   read ports (>=1)
//  ZERO_REG    1   1: register NUM_REGS-1 reads 0, writes dropped; 0: ordinary register
// PORTS
//  clock           in   1                     rising-edge clock
//  reset           in   1                     synchronous, active-high reset
//  reg_write       in   1                     write enable
//  write_register  in   ADDR_WIDTH            write address
//  write_data      in   DATA_WIDTH            write data
//  read_register   in   NUM_READ*ADDR_WIDTH   read addresses; port k = [k*ADDR_WIDTH +: ADDR_WIDTH]
//  read_data       out  NUM_READ*DATA_WIDTH   read data; port k = [k*DATA_WIDTH +: DATA_WIDTH]
//  busy            out  1                     clear engine active; writes ignored, reads return 0
// BEHAVIOUR
//  - One clock (clock); reset is synchronous and active-high; sampled only on rising edge.
//  - FSM states: CLEAR, READY. Reset high at an edge -> state=CLEAR, clr_idx=0, regardless
//    of current state (reset mid-clear restarts from index 0).
//  - CLEAR: each edge with reset low writes 0 to registers[clr_idx], clr_idx++. After the
//    edge writing index NUM_REGS-1 -> READY. Clear takes exactly NUM_REGS cycles after
//    reset deasserts; busy=1 in CLEAR (incl. while reset held), 0 in READY.
//  - Reset values: busy=1 after first reset edge; read_data=0 while busy.
//  - Register contents are undefined until first clear completes; no other reset of array.
//  - Write (READY only): edge with reg_write=1 stores write_data at write_register.
//    Dropped if busy, if write_register>=NUM_REGS, or (ZERO_REG=1) if address==NUM_REGS-1.
//  - Read: combinational, zero latency, each port independent.
//    Priority per port: busy -> 0; addr>=NUM_REGS -> 0; ZERO_REG && addr==NUM_REGS-1 -> 0;
//    bypass: reg_write && addr==write_register (write not dropped) -> write_data;
//    else registers[addr].
//  - Multiple ports reading same address all return same value (incl. bypass).
//  - Reset and reg_write asserted together: reset wins, write dropped.
//  - No combinational path from reset to read_data except via busy register.
// TESTING
//  1 reset 1 cycle, NUM_REGS=32 -> busy=1 for exactly 32 edges after deassert; then all
//    regs read 0 on every port.
//  2 write r5=0xDEADBEEF, next cycle read r5 on port0 and port1 -> both 0xDEADBEEF.
//  3 bypass: reg_write=1, write_register=7, write_data=0x1234, read_register port0=7 same
//    cycle -> read_data port0=0x1234 before edge; r7 holds 0x1234 after.
//  4 ZERO_REG=1: write r31=0xFFFFFFFF -> r31 reads 0, no bypass; ZERO_REG=0 -> reads 0xFFFFFFFF.
//  5 reset at clear index 10, held 3 cycles -> clear restarts at 0, busy low 32 edges after
//    deassert; write attempted while busy (r3=0x55) -> r3 reads 0 afterwards.
//  6 NUM_REGS=16, ADDR_WIDTH=5: write addr 20 -> ignored; read addr 20 -> 0; NUM_READ=4
//    all four ports read distinct regs correctly in one cycle.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: write port, read ports and busy flag of the register file
interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ = 2
);
  logic reg_write;
  logic [ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0] write_data;
  logic [NUM_READ*ADDR_WIDTH-1:0] read_register;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic busy;
  modport master(output reg_write, write_register, write_data, read_register, input read_data, busy);
  modport slave(input reg_write, write_register, write_data, read_register, output read_data, busy);
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with zero register, write bypass and post-reset clear
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input logic clock,
  input logic reset,
  reg_file_mp_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] NREG = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(NUM_REGS - 1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic wr_ok;
  logic [ADDR_WIDTH-1:0] ra;
  logic [NUM_READ*DATA_WIDTH-1:0] rd;
  function automatic logic live(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < NREG && !(ZERO_REG != 0 && {1'b0, a} == LAST);
  endfunction
  always_comb begin
    wr_ok = !busy_q && bus.reg_write && live(bus.write_register);
    state_d = (state_q == CLEAR && {1'b0, clr_idx_q} == LAST) ? READY : state_q;
    clr_idx_d = state_q == CLEAR ? clr_idx_q + ADDR_WIDTH'(1) : clr_idx_q;
    busy_d = state_d == CLEAR;
    regs_d = regs_q;
    if (state_q == CLEAR) regs_d[clr_idx_q] = '0;
    else if (wr_ok) regs_d[bus.write_register] = bus.write_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      busy_q <= 1'b1;
      clr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      clr_idx_q <= clr_idx_d;
      regs_q <= regs_d;
    end
  end
  always_comb begin
    rd = '0;
    ra = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      ra = bus.read_register[k*ADDR_WIDTH +: ADDR_WIDTH];
      rd[k*DATA_WIDTH +: DATA_WIDTH] = (busy_q || !live(ra)) ? '0
                                     : (wr_ok && ra == bus.write_register) ? bus.write_data
                                     : regs_q[ra];
    end
  end
  assign bus.read_data = rd;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: three register-file configurations checked against a countdown/array reference model
module tb_reg_file_mp;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, we;
  logic [4:0] wa;
  logic [31:0] wd;
  logic [4:0] ra [3][4];
  int vectors = 0, miscompares = 0;
  int nregs [3] = '{32, 16, 32};
  int zr [3] = '{1, 0, 0};
  int nrd [3] = '{2, 4, 1};
  int cnt [3];
  logic [31:0] mem [3][32];
  bit init = 0;
  reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) ia();
  reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4)) ib();
  reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(1)) ic();
  reg_file_mp #(.NUM_REGS(32), .NUM_READ(2), .ZERO_REG(1)) dut_a(.clock(clock), .reset(reset), .bus(ia));
  reg_file_mp #(.NUM_REGS(16), .NUM_READ(4), .ZERO_REG(0)) dut_b(.clock(clock), .reset(reset), .bus(ib));
  reg_file_mp #(.NUM_REGS(32), .NUM_READ(1), .ZERO_REG(0)) dut_c(.clock(clock), .reset(reset), .bus(ic));
  assign ia.reg_write = we;
  assign ib.reg_write = we;
  assign ic.reg_write = we;
  assign ia.write_register = wa;
  assign ib.write_register = wa;
  assign ic.write_register = wa;
  assign ia.write_data = wd;
  assign ib.write_data = wd;
  assign ic.write_data = wd;
  assign ia.read_register = {ra[0][1], ra[0][0]};
  assign ib.read_register = {ra[1][3], ra[1][2], ra[1][1], ra[1][0]};
  assign ic.read_register = ra[2][0];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit wr_valid(int d);
    return we && cnt[d] == 0 && int'(wa) < nregs[d] && !(zr[d] != 0 && int'(wa) == nregs[d] - 1);
  endfunction
  function automatic logic [31:0] exp_rd(int d, logic [4:0] a);
    if (cnt[d] > 0 || int'(a) >= nregs[d]) return 32'h0;
    if (zr[d] != 0 && int'(a) == nregs[d] - 1) return 32'h0;
    if (wr_valid(d) && a == wa) return wd;
    return mem[d][a];
  endfunction
  function automatic logic [31:0] obs(int d, int k);
    case (d)
      0: return ia.read_data[k*32 +: 32];
      1: return ib.read_data[k*32 +: 32];
      default: return ic.read_data[31:0];
    endcase
  endfunction
  function automatic logic obs_busy(int d);
    return d == 0 ? ia.busy : d == 1 ? ib.busy : ic.busy;
  endfunction
  task automatic cycle();
    #1;
    if (init)
      for (int d = 0; d < 3; d++) begin
        check($sformatf("busy%0d", d), 32'(obs_busy(d)), 32'(cnt[d] > 0));
        for (int k = 0; k < nrd[d]; k++)
          check($sformatf("rd%0d_%0d@%0d", d, k, ra[d][k]), obs(d, k), exp_rd(d, ra[d][k]));
      end
    @(posedge clock);
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        cnt[d] = nregs[d];
      end else if (cnt[d] > 0) begin
        cnt[d]--;
        if (cnt[d] == 0)
          for (int i = 0; i < 32; i++) mem[d][i] = 32'h0;
      end else if (wr_valid(d)) begin
        mem[d][wa] = wd;
      end
    end
    if (reset) init = 1;
    @(negedge clock);
  endtask
  task automatic set_rd(input logic [4:0] a);
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) ra[d][k] = a;
  endtask
  task automatic rnd();
    we = 1'($urandom % 2);
    wa = 5'($urandom % 32);
    wd = $urandom;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) ra[d][k] = ($urandom % 3 == 0) ? wa : 5'($urandom % 32);
  endtask
  initial begin
    reset = 1; we = 0; wa = 0; wd = 0;
    set_rd(5'd0);
    @(negedge clock);
    cycle();
    reset = 0;
    for (int i = 0; i < 36; i++) begin rnd(); cycle(); end
    we = 1; wa = 5; wd = 32'hDEADBEEF; set_rd(5'd5); cycle();
    we = 0; cycle();
    we = 1; wa = 7; wd = 32'h1234; set_rd(5'd7); cycle();
    we = 0; cycle();
    we = 1; wa = 31; wd = 32'hFFFFFFFF; set_rd(5'd31); cycle();
    we = 0; cycle();
    we = 1; wa = 20; wd = 32'hABCD; set_rd(5'd20); cycle();
    we = 0; cycle();
    for (int i = 1; i <= 4; i++) begin we = 1; wa = 5'(i); wd = 32'(i * 32'h1111); cycle(); end
    we = 0;
    for (int k = 0; k < 4; k++) begin ra[0][k] = 5'(k + 1); ra[1][k] = 5'(k + 1); ra[2][k] = 5'(k + 1); end
    cycle();
    reset = 1; cycle();
    reset = 0;
    for (int i = 0; i < 10; i++) begin rnd(); cycle(); end
    we = 1; wa = 3; wd = 32'h55; set_rd(5'd3);
    reset = 1;
    for (int i = 0; i < 3; i++) cycle();
    reset = 0;
    for (int i = 0; i < 32; i++) cycle();
    we = 0; cycle();
    cycle();
    for (int i = 0; i < 400; i++) begin
      rnd();
      reset = ($urandom % 80 == 0);
      cycle();
    end
    reset = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
